// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the fetch/data memory arbiter.
//   arb_state_e  : arbiter FSM states
//   side_e       : which requester (fetch or data) a grant belongs to
//   ABORT_RDATA  : read data returned on a timed-out access
//   CNT_W        : width of the wait counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int          CNT_W       = 10;
    localparam logic [31:0] ABORT_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

endpackage

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Counts grant cycles that end without a memory acknowledge.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : increment this cycle
//   tc_o       : the current cycle is the LIMIT-th counted cycle
// -----------------------------------------------------------------------------
module wait_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // cnt_q holds the number of ack-less cycles already finished, so the
    // LIMIT-th such cycle is the one where cnt_q == LIMIT-1.
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a fetch port (read only) and a data port (read/write) onto one
// single-port memory. Ties alternate; an access that waits TIMEOUT_CYCLES
// grant cycles without m_ack is aborted and flags timeout_err (sticky).
//   clk, reset                    : clock, asynchronous active-high reset
//   i_req/i_addr                  : fetch request, held until i_ready
//   i_rdata/i_ready               : fetch read data + one-cycle completion
//   d_req/d_we/d_addr/d_wdata     : data request, held until d_ready
//   d_rdata/d_ready               : data read data + one-cycle completion
//   m_req/m_we/m_addr/m_wdata     : shared memory request
//   m_rdata/m_ack                 : memory read data + completion strobe
//   timeout_err                   : sticky abort flag
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        timeout_err
);

    arb_state_e  state_q;
    side_e       last_q;
    logic        i_ready_q, d_ready_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        m_req_q, m_we_q;
    logic [31:0] m_addr_q, m_wdata_q;
    logic        timeout_err_q;

    logic granted, tc, i_ok, d_ok, pick_d;

    assign granted = (state_q != IDLE);

    // A requester still sees its ready pulse during this cycle and has not
    // yet dropped its request; it must not be served a second time.
    assign i_ok = i_req & ~i_ready_q;
    assign d_ok = d_req & ~d_ready_q;

    // Data wins when alone or when fetch was served last.
    assign pick_d = d_ok & (~i_ok | (last_q == SIDE_I));

    wait_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr_i (~granted),
        .en_i  (granted & ~m_ack),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= SIDE_I;
            i_ready_q     <= 1'b0;
            d_ready_q     <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            m_req_q       <= 1'b0;
            m_we_q        <= 1'b0;
            m_addr_q      <= '0;
            m_wdata_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q   <= GRANT_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                    end else if (i_ok) begin
                        state_q   <= GRANT_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= i_addr;
                        m_wdata_q <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // An ack arriving in the terminal cycle completes normally.
                    if (m_ack || tc) begin
                        if (state_q == GRANT_I) begin
                            i_rdata_q <= m_ack ? m_rdata : ABORT_RDATA;
                            i_ready_q <= 1'b1;
                            last_q    <= SIDE_I;
                        end else begin
                            d_rdata_q <= m_ack ? m_rdata : ABORT_RDATA;
                            d_ready_q <= 1'b1;
                            last_q    <= SIDE_D;
                        end
                        if (!m_ack)
                            timeout_err_q <= 1'b1;
                        state_q <= IDLE;
                        m_req_q <= 1'b0;
                        m_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                    m_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_ready     = i_ready_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Transaction-level bench: each access is modelled as "who is granted, how
// many cycles m_req stays up, what read data comes back, does the error flag
// set", derived from the arbitration and timeout rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready;
    logic        m_req, m_we, m_ack, timeout_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_ready     (i_ready),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state: last side served (0=I,1=D), sticky error, held read
    // data per side, side whose ready pulse is visible this cycle (-1 none)
    int          last_m;
    bit          err_m;
    logic [31:0] ir_m, dr_m;
    int          done_m;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_m = 0; err_m = 1'b0; ir_m = '0; dr_m = '0; done_m = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state();
        chk("rst_mreq",  m_req, 0);
        chk("rst_mwe",   m_we, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_mwdat", m_wdata, 0);
        chk("rst_ready", {i_ready, d_ready}, 0);
        chk("rst_irdat", i_rdata, 0);
        chk("rst_drdat", d_rdata, 0);
        chk("rst_err",   timeout_err, 0);
    endtask

    task automatic raise_i(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    // Called in a cycle where the arbiter is idle. Predicts the grant from the
    // current requests, acks in grant cycle k (k > TO means never), optionally
    // drops the winner's request mid-access, and checks the whole access.
    task automatic serve_next(input int k, input logic [31:0] rd, input bit drop);
        bit          ei, ed;
        int          win, n;
        logic [31:0] ea, ew, exp_rd;
        logic        ewe;
        ei = i_req && (done_m != 0);
        ed = d_req && (done_m != 1);
        if (!ei && !ed) begin
            tick();
            if (done_m == 0) i_req = 0;
            if (done_m == 1) d_req = 0;
            done_m = -1;
            chk("idle_mreq",  m_req, 0);
            chk("idle_mwe",   m_we, 0);
            chk("idle_ready", {i_ready, d_ready}, 0);
            chk("idle_err",   timeout_err, err_m);
            return;
        end
        win = (ed && (!ei || last_m == 0)) ? 1 : 0;
        ea  = win ? d_addr : i_addr;
        ewe = win ? d_we : 1'b0;
        ew  = d_wdata;
        tick();
        if (done_m == 0) i_req = 0;
        if (done_m == 1) d_req = 0;
        n = (k <= TO) ? k : TO;
        for (int c = 1; c <= n; c++) begin
            chk("grant_mreq", m_req, 1);
            chk("grant_addr", m_addr, ea);
            chk("grant_we",   m_we, ewe);
            if (win == 1) chk("grant_wdata", m_wdata, ew);
            chk("grant_ready", {i_ready, d_ready}, 0);
            if (drop && c == 1) begin
                if (win == 1) d_req = 0; else i_req = 0;
            end
            m_ack   = (c == k);
            m_rdata = (c == k) ? rd : $urandom;
            tick();
            m_ack = 0;
        end
        if (k > TO) err_m = 1'b1;
        exp_rd = (k <= TO) ? rd : 32'h0000_0000;
        if (win == 1) dr_m = exp_rd; else ir_m = exp_rd;
        last_m = win;
        chk(win ? "d_ready" : "i_ready", win ? d_ready : i_ready, 1);
        chk(win ? "i_ready_off" : "d_ready_off", win ? i_ready : d_ready, 0);
        chk("done_mreq", m_req, 0);
        chk("done_mwe",  m_we, 0);
        chk("i_rdata",   i_rdata, ir_m);
        chk("d_rdata",   d_rdata, dr_m);
        chk("timeout_err", timeout_err, err_m);
        done_m = win;
    endtask

    task automatic rand_raise();
        if (!i_req && done_m != 0 && $urandom_range(0, 1) == 1)
            raise_i($urandom);
        if (!d_req && done_m != 1 && $urandom_range(0, 1) == 1)
            raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    initial begin
        // reset values
        apply_reset();
        check_reset_state();

        // single fetch, ack in first grant cycle
        raise_i(32'h40);
        serve_next(1, 32'h1357_9BDF, 0);
        serve_next(1, 32'h0, 0);

        // simultaneous requests after reset: D, I, D, I
        apply_reset();
        raise_i(32'h1000);
        raise_d(0, 32'h2000, 32'h0);
        serve_next(1, 32'hD000_0001, 0);
        serve_next(1, 32'hA000_0001, 0);
        raise_d(0, 32'h2004, 32'h0);
        serve_next(1, 32'hD000_0002, 0);
        raise_i(32'h1004);
        serve_next(1, 32'hA000_0002, 0);
        serve_next(1, 32'h0, 0);
        // tie with data served last goes to fetch
        raise_d(0, 32'h2008, 32'h0);
        serve_next(1, 32'hD000_0003, 0);
        serve_next(1, 32'h0, 0);
        raise_i(32'h1008);
        raise_d(0, 32'h200C, 32'h0);
        serve_next(1, 32'hA000_0003, 0);
        serve_next(1, 32'hD000_0004, 0);

        // write held for 4 grant cycles (ack in the terminal cycle wins)
        apply_reset();
        raise_d(1, 32'h100, 32'hCAFE_F00D);
        serve_next(4, 32'h0, 0);
        chk("ack_at_limit_err", timeout_err, 0);

        // timeout abort, sticky flag, cleared only by reset
        apply_reset();
        raise_i(32'h40);
        serve_next(2, 32'hA5A5_0001, 0);
        serve_next(1, 32'h0, 0);
        raise_i(32'h44);
        serve_next(TO + 1, 32'h0, 0);
        serve_next(1, 32'h0, 0);
        serve_next(1, 32'h0, 0);
        raise_i(32'h48);
        serve_next(TO, 32'h1234_0001, 0);
        apply_reset();
        check_reset_state();

        // request dropped while granted still completes
        raise_d(0, 32'h300, 32'h0);
        serve_next(2, 32'hBEEF_0001, 1);
        serve_next(1, 32'h0, 0);

        // reset in the middle of a data grant
        apply_reset();
        raise_d(1, 32'h200, 32'h1111_2222);
        tick();
        chk("rst_pre_mreq", m_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mreq", m_req, 0);
        chk("rst_async_mwe",  m_we, 0);
        d_req = 0;
        m_ack = 1; m_rdata = 32'hDEAD_BEEF;
        tick();
        m_ack = 0;
        chk("rst_no_dready", d_ready, 0);
        reset = 1'b0;
        model_reset();
        tick();
        chk("rst_rel_dready", d_ready, 0);
        chk("rst_rel_mreq",   m_req, 0);
        chk("rst_rel_drdata", d_rdata, 0);
        raise_i(32'h300);
        serve_next(1, 32'h5555_AAAA, 0);

        // randomized traffic
        apply_reset();
        for (int t = 0; t < 250; t++) begin
            rand_raise();
            serve_next($urandom_range(1, TO + 1), $urandom, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max wait cycles for m_ack before aborting (range 1..1023).
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have i_req  input  1  fetch-stage read request, held until i_ready sampled.
REQ-005 SHALL have i_addr  input  32  fetch address.
REQ-006 SHALL have i_rdata  output  32  fetch read data, valid when i_ready=1.
REQ-007 SHALL have i_ready  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have d_req  input  1  memory-stage request, held until d_ready sampled.
REQ-009 SHALL have d_we  input  1  memory-stage write enable (1=write).
REQ-010 SHALL have d_addr  input  32  data address.
REQ-011 SHALL have d_wdata  input  32  data write value.
REQ-012 SHALL have d_rdata  output  32  data read value, valid when d_ready=1.
REQ-013 SHALL have d_ready  output  1  one-cycle data completion pulse.
REQ-014 SHALL have m_req, m_we  output  1 each  shared single-port memory request/write enable.
REQ-015 SHALL have m_addr, m_wdata  output  32 each  shared memory address/write data.
REQ-016 SHALL have m_rdata  input  32 and m_ack  input  1  memory read data and completion strobe.
REQ-017 SHALL have timeout_err  output  1  sticky abort flag.

Function
REQ-018 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-019 In IDLE, a requester whose ready output is 1 that cycle SHALL be ignored.
REQ-020 In IDLE with one eligible request, SHALL enter the matching GRANT state next cycle, latching addr/we/wdata (we=0 for fetch).
REQ-021 In IDLE with both eligible, SHALL grant the requester not granted last (last_grant flag); after reset last_grant=I, so data wins the first tie.
REQ-022 In GRANT_x, m_req SHALL be 1 and m_addr/m_we/m_wdata SHALL drive the latched values; in IDLE m_req=0, m_we=0.
REQ-023 On m_ack=1 in GRANT_x, SHALL register m_rdata into x_rdata, pulse x_ready=1 the next cycle, return to IDLE, and update last_grant.
REQ-024 Minimum request-to-ready latency SHALL be 2 cycles (ack in first GRANT cycle); the next grant begins no earlier than the cycle after ready.
REQ-025 A wait counter SHALL clear on GRANT entry and increment each GRANT cycle without m_ack.
REQ-026 When the counter equals TIMEOUT_CYCLES without m_ack, SHALL abort: x_ready pulse, x_rdata=32'h0000_0000, timeout_err set, return to IDLE.
REQ-027 m_ack in the timeout cycle SHALL win: normal completion, no error.
REQ-028 timeout_err SHALL stay set until reset.
REQ-029 x_rdata SHALL hold its last value between ready pulses.
REQ-030 A request dropped while granted SHALL NOT abort the memory access; completion still pulses ready.

Reset
REQ-031 Reset SHALL force IDLE, last_grant=I, counter=0, i_ready=d_ready=0, i_rdata=d_rdata=0, timeout_err=0, m_req=0, m_we=0, m_addr=m_wdata=0, and latched address/data=0.
REQ-032 Reset mid-GRANT SHALL drop m_req immediately (asynchronously) and SHALL NOT emit any ready pulse.

Structure
REQ-033 State enum, grant-side enum, and abort read value SHALL live in shared package mem_arb_pkg.
REQ-034 Timeout counter SHALL be sub-module wait_counter (clear, enable, terminal-count compare).
REQ-035 Counter width SHALL be 10 bits.

Verification
REQ-036 Only i_req, addr 0x40, ack 1 cycle after GRANT_I -> m_req 1 cycle, m_addr=0x40, m_we=0, i_ready pulse with i_rdata=m_rdata.
REQ-037 i_req and d_req same cycle after reset, ack each in 1 cycle -> D served first, then I; repeated ties alternate D,I,D,I.
REQ-038 d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D, ack after 3 cycles -> m_we=1, m_wdata=0xCAFE_F00D held 4 cycles, d_ready 1 cycle.
REQ-039 TIMEOUT_CYCLES=4, no ack -> abort after 4 GRANT cycles, i_rdata=0, timeout_err=1 until reset; ack on cycle 4 -> no error.
REQ-040 Reset asserted during GRANT_D -> m_req=0 same cycle, no d_ready, FSM IDLE after release.
